// File: rtl/opb_register_simulink2ppc_snap.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_simulink2ppc_snap
// Brief    : OPB slave readback register: captures a fabric value on a strobe
//            and exposes DATA / STATUS / CTRL to the processor.
// Revision : 1.0 - initial release
// ============================================================================
module opb_register_simulink2ppc_snap #(
   parameter logic [31:0] C_BASEADDR   = 32'h01000200,
   parameter logic [31:0] C_HIGHADDR   = 32'h010002FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "virtex6"
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   input  logic [31:0]                 user_data_in,
   input  logic                        user_data_valid
);

   localparam logic [1:0] c_sel_data   = 2'd0;
   localparam logic [1:0] c_sel_status = 2'd1;
   localparam logic [1:0] c_sel_ctrl   = 2'd2;

   // Bus-side transfer state latched in the hit cycle
   logic        r_ack;
   logic [31:0] r_dbus;
   logic        r_rnw;
   logic [1:0]  r_sel;
   logic        r_wr_be;
   logic        r_wr_frz;
   logic        r_wr_clr;

   // User-visible register state
   logic [31:0] r_data;
   logic        r_new;
   logic        r_ovr;
   logic        r_frz;
   logic [15:0] r_count;

   logic        w_in_range;
   logic        w_hit;
   logic [1:0]  w_sel;
   logic [31:0] w_rd_mux;
   logic        w_cap;
   logic        w_clr_new;
   logic        w_clr_ovr;
   logic        w_ctrl_wr;
   logic        w_unused;

   assign w_in_range = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign w_hit      = OPB_select && w_in_range && !r_ack;
   assign w_sel      = OPB_ABus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];

   always_comb begin
      w_rd_mux = 32'h0;
      case (w_sel)
         c_sel_data:   w_rd_mux = r_data;
         c_sel_status: w_rd_mux = {r_new, r_ovr, 13'h0, r_frz, r_count};
         c_sel_ctrl:   w_rd_mux = {31'h0, r_frz};
         default:      w_rd_mux = 32'h0;
      endcase
   end

   // Side effects land at the edge that ends the ack cycle
   assign w_cap     = user_data_valid && !r_frz;
   assign w_clr_new = r_ack && r_rnw && (r_sel == c_sel_data);
   assign w_clr_ovr = r_ack && r_rnw && (r_sel == c_sel_status);
   assign w_ctrl_wr = r_ack && !r_rnw && (r_sel == c_sel_ctrl) && r_wr_be;

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         r_ack    <= 1'b0;
         r_dbus   <= 32'h0;
         r_rnw    <= 1'b0;
         r_sel    <= 2'd0;
         r_wr_be  <= 1'b0;
         r_wr_frz <= 1'b0;
         r_wr_clr <= 1'b0;
      end else begin
         r_ack  <= w_hit;
         r_dbus <= (w_hit && OPB_RNW) ? w_rd_mux : 32'h0;
         if (w_hit) begin
            r_rnw    <= OPB_RNW;
            r_sel    <= w_sel;
            r_wr_be  <= OPB_BE[C_OPB_DWIDTH/8-1];
            r_wr_frz <= OPB_DBus[C_OPB_DWIDTH-1];
            r_wr_clr <= OPB_DBus[C_OPB_DWIDTH-2];
         end
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         r_data  <= 32'h0;
         r_new   <= 1'b0;
         r_ovr   <= 1'b0;
         r_frz   <= 1'b0;
         r_count <= 16'h0;
      end else begin
         if (w_cap) begin
            r_data <= user_data_in;
         end

         // A capture in the same cycle as a clearing read keeps the flag set
         if (w_cap) begin
            r_new <= 1'b1;
         end else if (w_clr_new) begin
            r_new <= 1'b0;
         end

         if (w_cap && r_new) begin
            r_ovr <= 1'b1;
         end else if (w_clr_ovr) begin
            r_ovr <= 1'b0;
         end

         if (w_ctrl_wr && r_wr_clr) begin
            r_count <= 16'h0;
         end else if (w_cap) begin
            r_count <= r_count + 16'd1;
         end

         if (w_ctrl_wr) begin
            r_frz <= r_wr_frz;
         end
      end
   end

   assign Sl_DBus    = r_dbus;
   assign Sl_xferAck = r_ack;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   assign w_unused = &{1'b0, OPB_seqAddr, OPB_BE[0:C_OPB_DWIDTH/8-2],
                       OPB_DBus[0:C_OPB_DWIDTH-3]};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc_snap.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_register_simulink2ppc_snap
// Brief    : Scoreboard bench with a behavioural register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opb_register_simulink2ppc_snap;

   localparam logic [31:0] BASE = 32'h01000200;
   localparam logic [31:0] HIGH = 32'h010002FF;

   logic        OPB_Clk = 1'b0;
   logic        OPB_Rst;
   logic [0:31] OPB_ABus;
   logic [0:3]  OPB_BE;
   logic [0:31] OPB_DBus;
   logic        OPB_RNW;
   logic        OPB_select;
   logic        OPB_seqAddr;
   logic [0:31] Sl_DBus;
   logic        Sl_xferAck;
   logic        Sl_errAck;
   logic        Sl_retry;
   logic        Sl_toutSup;
   logic [31:0] user_data_in;
   logic        user_data_valid;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   // Reference model state
   logic [31:0] m_data;
   bit          m_new, m_ovr, m_frz;
   int unsigned m_cnt;

   opb_register_simulink2ppc_snap dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
      .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
      .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
      .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
      .user_data_in(user_data_in), .user_data_valid(user_data_valid)
   );

   always #5 OPB_Clk = ~OPB_Clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every ack pops one expected bus value
   always @(negedge OPB_Clk) begin
      logic [31:0] e;
      check32("tie_offs", {29'h0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
      if (Sl_xferAck) begin
         if (exp_q.size() == 0) begin
            check32("unexpected_ack", 32'h1, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check32("ack_data", Sl_DBus, e);
         end
      end else begin
         check32("idle_dbus", Sl_DBus, 32'h0);
      end
   end

   function automatic logic [31:0] m_read(input int sel);
      case (sel)
         0: return m_data;
         1: return (32'(m_new) << 31) | (32'(m_ovr) << 30) | (32'(m_frz) << 16) | (m_cnt % 65536);
         2: return 32'(m_frz);
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_data = 32'h0; m_new = 0; m_ovr = 0; m_frz = 0; m_cnt = 0;
   endtask

   task automatic m_apply(input bit ack, input bit rnw, input int sel, input logic [0:3] be,
                          input logic [31:0] wd, input bit stb, input logic [31:0] sv);
      bit cap;
      bit old_new;
      cap     = stb && !m_frz;
      old_new = m_new;
      if (ack && rnw && sel == 0) m_new = 0;
      if (ack && rnw && sel == 1) m_ovr = 0;
      if (cap) begin
         m_data = sv;
         m_cnt  = (m_cnt + 1) % 65536;
         m_new  = 1;
         if (old_new) m_ovr = 1;
      end
      if (ack && !rnw && sel == 2 && be[3]) begin
         m_frz = wd[0];
         if (wd[1]) m_cnt = 0;
      end
   endtask

   task automatic tick();
      @(posedge OPB_Clk);
      #1;
   endtask

   // One transfer: hit cycle, ack cycle (optional strobe), then model update
   task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [0:3] be,
                       input logic [31:0] wd, input bit stb, input logic [31:0] sv,
                       input bit lit, input logic [31:0] lit_val);
      bit in_rng;
      int sel;
      in_rng = (addr >= BASE) && (addr <= HIGH);
      sel    = int'((addr / 4) % 4);
      OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = wd; OPB_select = 1'b1;
      if (in_rng) exp_q.push_back(rnw ? (lit ? lit_val : m_read(sel)) : 32'h0);
      tick();
      OPB_select = 1'b0;
      if (stb) begin
         user_data_valid = 1'b1;
         user_data_in    = sv;
      end
      check32("ack_latency", 32'(Sl_xferAck), 32'(in_rng));
      tick();
      user_data_valid = 1'b0;
      check32("ack_width", 32'(Sl_xferAck), 32'h0);
      m_apply(in_rng, rnw, sel, be, wd, stb, sv);
   endtask

   task automatic rd_lit(input logic [31:0] off, input logic [31:0] val);
      xfer(BASE + off, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, val);
   endtask

   task automatic rd_stb_lit(input logic [31:0] off, input logic [31:0] sv, input logic [31:0] val);
      xfer(BASE + off, 1'b1, 4'b1111, 32'h0, 1'b1, sv, 1'b1, val);
   endtask

   task automatic wr(input logic [31:0] off, input logic [0:3] be, input logic [31:0] wd,
                     input bit stb, input logic [31:0] sv);
      xfer(BASE + off, 1'b0, be, wd, stb, sv, 1'b0, 32'h0);
   endtask

   task automatic strobe(input logic [31:0] v);
      user_data_valid = 1'b1;
      user_data_in    = v;
      tick();
      user_data_valid = 1'b0;
      m_apply(1'b0, 1'b0, 0, 4'b0000, 32'h0, 1'b1, v);
   endtask

   initial begin
      OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
      OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_data_valid = 1'b0;
      m_reset();
      repeat (3) tick();
      OPB_Rst = 1'b0;
      tick();

      // Reset values
      rd_lit(0, 32'h0);
      rd_lit(4, 32'h0);

      // Single capture, NEW cleared by DATA read
      strobe(32'hDEADBEEF);
      rd_lit(4, 32'h80000001);
      rd_lit(0, 32'hDEADBEEF);
      rd_lit(4, 32'h00000001);

      // Reset coincident with a hit: no ack, state returns to reset values
      OPB_Rst = 1'b1; OPB_select = 1'b1; OPB_ABus = BASE; OPB_RNW = 1'b1;
      tick();
      OPB_select = 1'b0;
      check32("rst_no_ack", 32'(Sl_xferAck), 32'h0);
      OPB_Rst = 1'b0;
      m_reset();
      tick();
      check32("rst_no_ack_late", 32'(Sl_xferAck), 32'h0);

      // Overrun
      strobe(32'h1);
      strobe(32'h2);
      rd_lit(4, 32'hC0000002);
      rd_lit(4, 32'h80000002);
      rd_lit(0, 32'h00000002);

      // Freeze and byte-lane qualification of CTRL writes
      wr(8, 4'b1111, 32'h1, 1'b0, 32'h0);
      strobe(32'h55);
      rd_lit(0, 32'h00000002);
      rd_lit(4, 32'h00010002);
      wr(8, 4'b1110, 32'h0, 1'b0, 32'h0);
      rd_lit(4, 32'h00010002);
      rd_lit(8, 32'h00000001);
      wr(8, 4'b1111, 32'h0, 1'b0, 32'h0);
      rd_lit(4, 32'h00000002);

      // Counter wrap after 65536 captures
      wr(8, 4'b1111, 32'h2, 1'b0, 32'h0);
      for (int i = 0; i < 65536; i++) begin
         user_data_valid = 1'b1;
         user_data_in    = 32'(i);
         tick();
         m_apply(1'b0, 1'b0, 0, 4'b0000, 32'h0, 1'b1, 32'(i));
      end
      user_data_valid = 1'b0;
      rd_lit(4, 32'hC0000000);
      // Counter clear overrides a coincident increment
      wr(8, 4'b1111, 32'h2, 1'b1, 32'hA5A5A5A5);
      rd_lit(0, 32'hA5A5A5A5);
      rd_lit(4, 32'h40000000);

      // Capture during the clearing read's ack cycle
      strobe(32'h11111111);
      rd_stb_lit(0, 32'h22222222, 32'h11111111);
      rd_lit(4, 32'hC0000002);
      rd_lit(0, 32'h22222222);
      strobe(32'h33);
      strobe(32'h44);
      rd_stb_lit(4, 32'h55, 32'hC0000004);
      rd_lit(4, 32'hC0000005);
      rd_lit(12, 32'h0);

      // Select held through the ack cycle yields one ack
      OPB_ABus = BASE + 32'h8; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
      exp_q.push_back(m_read(2));
      tick();
      check32("held_ack", 32'(Sl_xferAck), 32'h1);
      tick();
      check32("held_single_ack", 32'(Sl_xferAck), 32'h0);
      OPB_select = 1'b0;
      tick();

      // Out of range
      xfer(32'h01000300, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      xfer(32'h010001FC, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         int r;
         logic [31:0] addr, wd;
         r = int'($urandom_range(0, 9));
         if (r < 3) begin
            strobe($urandom);
         end else if (r == 3) begin
            addr = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 256))
                                               : HIGH + 32'($urandom_range(1, 256));
            xfer(addr, 1'($urandom), 4'($urandom), $urandom, 1'($urandom), $urandom, 1'b0, 32'h0);
         end else begin
            addr = BASE + 32'($urandom_range(0, 255));
            wd   = $urandom & 32'hFFFFFFFC;
            if ($urandom_range(0, 4) == 0) wd[0] = 1'b1;
            if ($urandom_range(0, 4) == 0) wd[1] = 1'b1;
            xfer(addr, $urandom_range(0, 2) != 0, 4'($urandom), wd,
                 1'($urandom), $urandom, 1'b0, 32'h0);
         end
      end

      xfer(BASE + 4, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      xfer(BASE, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (3) tick();
      check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
